// File: rtl/fifo_wctrl_m_w.sv
// Write-side controller for the M->W async FIFO (wclk domain).
// Owns the binary/Gray write pointers and the registered full/almost-full flags.
module fifo_wctrl_m_w #(
  parameter int ADDRSIZE     = 4,
  parameter int DATASIZE     = 37,
  parameter int AFULL_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [DATASIZE-1:0] s_wdata,
  input  logic                s_wvalid,
  output logic                s_wready,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [DATASIZE-1:0] wdata,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wpush,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wcount,
  output logic                wburst_done
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AF_LVL =
    (ADDRSIZE+1)'(DEPTH - AFULL_THRESH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] used_next;
  logic              accept;
  logic              wfull_next;
  logic              wafull_next;

  assign accept = s_wvalid & s_wready;
  assign wpush  = accept;
  assign wdata  = s_wdata;
  assign waddr  = wbin[ADDRSIZE-1:0];

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++)
      rbin[i] = ^(wq2_rptr >> i);
  end

  assign wbin_next  = wbin + (ADDRSIZE+1)'(accept);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer has lapped the read pointer once.
  assign full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                     wq2_rptr[ADDRSIZE-2:0]};

  assign wfull_next  = (wgray_next == full_cmp);
  assign used_next   = wbin_next - rbin;
  assign wafull_next = (used_next >= AF_LVL);
  assign wcount      = wbin - rbin;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      s_wready     <= 1'b0;
      wburst_done  <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= wafull_next;
      s_wready     <= ~wfull_next;
      wburst_done  <= accept & s_wdata[DATASIZE-1];
    end
  end

endmodule

// File: tb/tb_fifo_wctrl_m_w.sv
// Directed bench for fifo_wctrl_m_w.
// Occupancy model plus write scoreboard checked every cycle.
module tb_fifo_wctrl_m_w;

  localparam int AW = 4;
  localparam int DW = 37;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic [DW-1:0] s_wdata = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [AW:0]   wq2_rptr = '0;
  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr;
  logic          wpush;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wptr;
  logic [AW:0]   wcount;
  logic          wburst_done;

  fifo_wctrl_m_w #(
    .ADDRSIZE(AW),
    .DATASIZE(DW),
    .AFULL_THRESH(2)
  ) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .s_wdata(s_wdata),
    .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .wq2_rptr(wq2_rptr),
    .wdata(wdata),
    .waddr(waddr),
    .wpush(wpush),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wptr(wptr),
    .wcount(wcount),
    .wburst_done(wburst_done)
  );

  always #5 wclk = ~wclk;

  int vec = 0;
  int errs = 0;
  logic [AW+DW-1:0] sb[$];
  int   m_wbin = 0;
  int   m_rb = 0;
  logic m_ready = 1'b0;
  logic m_full = 1'b0;
  logic m_afull = 1'b0;
  logic m_bd = 1'b0;
  int   pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic int g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  function automatic logic [AW:0] b2g(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  task automatic cyc(input logic v, input logic [DW-1:0] d,
                     input logic [AW:0] rg);
    logic acc;
    int rb;
    int occ;
    logic [AW+DW-1:0] e;
    logic [AW:0] prev;
    s_wvalid = v;
    s_wdata  = d;
    wq2_rptr = rg;
    #1;
    acc = v & m_ready;
    rb  = g2b(rg);
    if (acc) sb.push_back({m_wbin[AW-1:0], d});
    chk("wpush", wpush, acc);
    chk("wcount", wcount, (m_wbin - rb) & 31);
    if (wpush === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("waddr", waddr, e[AW+DW-1:DW]);
      chk("wdata", wdata, e[DW-1:0]);
    end
    prev = wptr;
    @(posedge wclk);
    #1;
    m_wbin  = (m_wbin + int'(acc)) & 31;
    occ     = (m_wbin - rb) & 31;
    m_full  = (occ == 16);
    m_afull = (occ >= 14);
    m_ready = !m_full;
    m_bd    = acc & d[DW-1];
    if (wburst_done === 1'b1) pulses++;
    chk("wfull", wfull, m_full);
    chk("walmost_full", walmost_full, m_afull);
    chk("s_wready", s_wready, m_ready);
    chk("wburst_done", wburst_done, m_bd);
    chk("wptr", wptr, b2g(m_wbin));
    chk("wptr_1bit", $countones(wptr ^ prev), acc);
  endtask

  task automatic rst_cyc(input logic v);
    wrst_n   = 1'b0;
    s_wvalid = v;
    s_wdata  = '1;
    wq2_rptr = '0;
    @(posedge wclk);
    #1;
    m_wbin = 0;
    m_rb = 0;
    m_ready = 1'b0;
    m_full = 1'b0;
    m_afull = 1'b0;
    m_bd = 1'b0;
    sb.delete();
    chk("rst_ready", s_wready, 0);
    chk("rst_wpush", wpush, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_afull", walmost_full, 0);
    chk("rst_bdone", wburst_done, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wcount", wcount, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [AW:0]   rg;
    logic          v;
    int            acc_n;
    int            beat;

    repeat (3) rst_cyc(1'b1);
    wrst_n = 1'b1;
    cyc(1'b0, '0, '0);
    chk("ready_after_rel", s_wready, 1);

    for (int i = 0; i < 16; i++)
      cyc(1'b1, DW'(i * 7 + 3), '0);
    chk("full16", wfull, 1);
    chk("wptr16", wptr, 5'b11000);
    chk("afull16", walmost_full, 1);
    chk("wcount16", wcount, 16);
    cyc(1'b1, 37'h0_aaaa_5555, '0);

    cyc(1'b0, '0, 5'b00001);
    chk("unfull_ready", s_wready, 1);
    cyc(1'b1, 37'h0_0000_1234, 5'b00001);
    chk("refull", wfull, 1);
    chk("wptr17", wptr, 5'b11001);
    m_rb = 1;

    acc_n = 0;
    for (int n = 0; n < 200 && acc_n < 40; n++) begin
      if (((m_wbin - m_rb) & 31) != 0) m_rb = (m_rb + 1) & 31;
      if (m_ready) acc_n++;
      cyc(1'b1, {5'b0, $urandom()}, b2g(m_rb));
    end
    chk("chase_count", acc_n, 40);

    beat = 0;
    pulses = 0;
    for (int n = 0; n < 40 && beat < 10; n++) begin
      v = (n % 3 != 2);
      if (((m_wbin - m_rb) & 31) != 0) m_rb = (m_rb + 1) & 31;
      d = {(beat == 3 || beat == 8), 4'hf, 32'(n)};
      if (v && m_ready) beat++;
      cyc(v, d, b2g(m_rb));
    end
    cyc(1'b0, '0, b2g(m_rb));
    chk("burst_pulses", pulses, 2);

    rg = b2g(m_rb);
    for (int n = 0; n < 20 && !m_full; n++)
      cyc(1'b1, 37'h0_0000_00ee, rg);
    chk("stall_full", wfull, 1);
    cyc(1'b1, 37'h1_f000_0bad, rg);
    chk("stall_no_pulse", wburst_done, 0);

    rst_cyc(1'b0);
    wrst_n = 1'b1;
    cyc(1'b0, '0, '0);
    for (int i = 0; i < 7; i++)
      cyc(1'b1, {(i == 6), 4'h3, 32'(i + 100)}, '0);
    chk("pre_rst_bdone", wburst_done, 1);
    chk("pre_rst_count", wcount, 7);
    rst_cyc(1'b1);
    wrst_n = 1'b1;
    cyc(1'b1, 37'h0_0000_0042, '0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, DW'(i + 200), '0);
    chk("post_rst_waddr", waddr, 3);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/fifo_wctrl_m_w.md
Name: fifo_wctrl_M_W

Overview:
Write-side controller for the M→W async FIFO. It runs in the write clock domain and accepts AXI W-channel beats from the master side over a valid/ready handshake. It drives the FIFO memory's write address, write data and push, and maintains the binary and Gray write pointers. It generates the registered full and almost-full flags from the read pointer, which arrives already synchronised into this domain.

Parameters:
ADDRSIZE, 4, FIFO address width; DEPTH = 2**ADDRSIZE entries
DATASIZE, 37, beat width = {WLAST, WSTRB[3:0], WDATA[31:0]}; bit DATASIZE-1 is WLAST
AFULL_THRESH, 2, walmost_full asserts when free entries <= AFULL_THRESH

Ports:
wclk  in  1  write-domain clock; all state updates on its rising edge
wrst_n  in  1  synchronous active-low reset, sampled on rising wclk
s_wdata  in  DATASIZE  beat from master side
s_wvalid  in  1  beat valid
s_wready  out  1  controller can accept beat
wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already 2-flop synchronised into wclk
wdata  out  DATASIZE  to FIFO memory write data
waddr  out  ADDRSIZE  to FIFO memory write address
wpush  out  1  to FIFO memory write enable
wfull  out  1  FIFO full, registered
walmost_full  out  1  free entries <= AFULL_THRESH, registered
wptr  out  ADDRSIZE+1  Gray write pointer, registered, sent to read-domain synchroniser
wcount  out  ADDRSIZE+1  occupancy as seen by write side, 0..DEPTH
wburst_done  out  1  one-cycle pulse after a beat with WLAST is written

Behaviour:
- Registers: wbin[ADDRSIZE:0], wptr, wfull, walmost_full, s_wready, wburst_done.
- Reset (wrst_n=0 at edge): wbin=0, wptr=0, wfull=0, walmost_full=0, s_wready=0, wburst_done=0.
- s_wready becomes 1 on the first edge after reset release (FIFO empty).
- Handshake: accept = s_wvalid & s_wready.
- wpush = accept, combinational. wdata = s_wdata, pass-through. waddr = wbin[ADDRSIZE-1:0].
- The memory writes on the same edge as accept, so write latency is 0 cycles.
- s_wvalid may assert or deassert freely. No beat is dropped or duplicated. The controller never depends on s_wready to raise s_wvalid.
- Pointer update: wbin_next = wbin + accept, modulo 2**(ADDRSIZE+1). wgray_next = (wbin_next >> 1) ^ wbin_next. wptr <= wgray_next.
- Full: wfull_next = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- wfull <= wfull_next and s_wready <= ~wfull_next. Hence s_wready == ~wfull at all times after the first post-reset cycle.
- Occupancy: rbin = Gray-to-binary(wq2_rptr). wcount = wbin - rbin, computed modulo 2**(ADDRSIZE+1) from registers (combinational).
- Almost-full: walmost_full <= ((wbin_next - rbin) mod 2**(ADDRSIZE+1)) >= DEPTH - AFULL_THRESH.
- Full when DEPTH-1 entries are occupied and a push occurs: wfull rises on that edge. The next beat is stalled (s_wready=0, wpush=0). The memory's own wfull guard is never relied on.
- Full plus read advance: when wq2_rptr advances, wfull clears at the next edge, so s_wready returns 1 cycle after the changed wq2_rptr is sampled.
- A simultaneous push and read advance in the same cycle is evaluated with both applied: occupancy is unchanged and the flags are recomputed.
- Wrap-around: wbin wraps 2**(ADDRSIZE+1)-1 → 0. The Gray wrap changes exactly 1 bit. The wrap bit (MSB) distinguishes full from empty.
- wptr changes by at most one Gray bit per cycle and is glitch-free (register output only).
- wburst_done <= accept & s_wdata[DATASIZE-1]. It pulses for 1 cycle after the WLAST beat.
- Reset mid-burst: all state returns to reset values in one edge. The read side must be reset concurrently.
- wq2_rptr is never advanced past wptr by a correct read side. If it is, behaviour is undefined.

Test Plan:
- Reset hold 3 cycles with s_wvalid=1 → s_wready=0, wpush=0 throughout. First edge after release → s_wready=1, wptr=0, wcount=0.
- Push 16 beats back-to-back, wq2_rptr=0 → waddr 0..15. wfull=1 after the 16th edge, wcount=16, wptr=5'b11000. The 17th beat is stalled with wpush=0. walmost_full rose after the 14th push.
- At full, set wq2_rptr=5'b00001 (rbin=1) → wfull=0 and s_wready=1 the next edge. One push → wfull=1 again, waddr=0, wbin=17.
- With continuous read chase, push 40 beats → wbin wraps 31→0, waddr wraps 15→0. Every consecutive wptr differs in exactly 1 bit.
- Beats with s_wdata[36]=1 on beats 4 and 9 → wburst_done high for exactly 1 cycle after each. No pulse on stalled beats.
- Assert wrst_n=0 after 7 pushes mid-burst → next edge gives wbin=0, wfull=0, walmost_full=0, wburst_done=0, s_wready=0. Release → normal operation from address 0.
